// File: rtl/button_conditioner_pkg.sv
// Shared types and constants for the bicycle light button front end.
package button_conditioner_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'b00,
      PRESS_WAIT   = 2'b01,
      HELD         = 2'b10,
      RELEASE_WAIT = 2'b11
   } db_state_t;

   localparam int unsigned BTN_NEXT   = 0;
   localparam int unsigned BTN_SLOWER = 1;
   localparam int unsigned BTN_FASTER = 2;

   // Bits needed to hold a counter value from 0 up to and including max_val.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return int'($clog2(max_val + 1));
   endfunction

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// One button channel: 2-flop synchroniser, saturating debounce counter and press FSM.
// Optional auto-repeat while held is built when AUTO_REPEAT_EN is defined.
module button_conditioner_debounce_channel
   import button_conditioner_pkg::*;
#(
   parameter int unsigned DB_CYCLES = 16
`ifdef AUTO_REPEAT_EN
  ,parameter int unsigned REP_CYCLES = 64
`endif
)(
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic pulse,
   output logic level
);

   localparam int unsigned CW = cnt_width(DB_CYCLES);

   logic          meta;
   logic          sync;
   db_state_t     state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          pulse_nxt;
   logic          level_nxt;
   logic          rep_fire;

   // Two-flop synchroniser for the asynchronous button level.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta <= 1'b0;
         sync <= 1'b0;
      end else begin
         meta <= raw;
         sync <= meta;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
         pulse <= 1'b0;
         level <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         pulse <= pulse_nxt;
         level <= level_nxt;
      end
   end

   // Counter is cleared on an accepted change so the next transition starts fresh.
   always_comb begin
      state_nxt = state;
      level_nxt = level;
      pulse_nxt = 1'b0;
      if (sync != level)
         cnt_nxt = (cnt == CW'(DB_CYCLES)) ? cnt : cnt + CW'(1);
      else
         cnt_nxt = '0;

      case (state)
         IDLE: begin
            if (sync)
               state_nxt = PRESS_WAIT;
         end
         PRESS_WAIT: begin
            if (!sync) begin
               state_nxt = IDLE;
            end else if (cnt == CW'(DB_CYCLES)) begin
               state_nxt = HELD;
               level_nxt = 1'b1;
               pulse_nxt = 1'b1;
               cnt_nxt   = '0;
            end
         end
         HELD: begin
            if (!sync)
               state_nxt = RELEASE_WAIT;
            else if (rep_fire)
               pulse_nxt = 1'b1;
         end
         RELEASE_WAIT: begin
            if (sync) begin
               state_nxt = HELD;
            end else if (cnt == CW'(DB_CYCLES)) begin
               state_nxt = IDLE;
               level_nxt = 1'b0;
               cnt_nxt   = '0;
            end
         end
      endcase
   end

`ifdef AUTO_REPEAT_EN
   localparam int unsigned RW = cnt_width(REP_CYCLES);

   logic [RW-1:0] rep, rep_nxt;

   // Repeat counter only advances while staying in HELD; any other state clears it.
   assign rep_fire = (state == HELD) && sync && (rep == RW'(REP_CYCLES - 1));

   always_comb begin
      rep_nxt = '0;
      if ((state == HELD) && sync && !rep_fire)
         rep_nxt = rep + RW'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         rep <= '0;
      else
         rep <= rep_nxt;
   end
`else
   assign rep_fire = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Debounces N_BTN raw push-buttons into clean levels and one-cycle press pulses.
// Define AUTO_REPEAT_EN to add periodic repeat pulses while a button is held.
module button_conditioner
   import button_conditioner_pkg::*;
#(
   parameter int unsigned N_BTN      = 3,
   parameter int unsigned DB_CYCLES  = 16,
   parameter int unsigned REP_CYCLES = 64
)(
   input  logic             clk,
   input  logic             reset,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_pulse,
   output logic [N_BTN-1:0] btn_level
);

   // Channels are fully independent; simultaneous presses pulse together.
   for (genvar i = 0; i < N_BTN; i++) begin : g_chan
      button_conditioner_debounce_channel #(
         .DB_CYCLES  (DB_CYCLES)
`ifdef AUTO_REPEAT_EN
        ,.REP_CYCLES (REP_CYCLES)
`endif
      ) u_chan (
         .clk   (clk),
         .reset (reset),
         .raw   (btn_raw[i]),
         .pulse (btn_pulse[i]),
         .level (btn_level[i])
      );
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed and random checks of button_conditioner against a run-length reference model.
module tb_button_conditioner;

   localparam int unsigned N   = 3;
   localparam int unsigned DB  = 4;
   localparam int unsigned REP = 8;
`ifdef AUTO_REPEAT_EN
   localparam bit REP_ON = 1'b1;
`else
   localparam bit REP_ON = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic [N-1:0] raw;
   logic [N-1:0] btn_pulse;
   logic [N-1:0] btn_level;

   button_conditioner #(.N_BTN(N), .DB_CYCLES(DB), .REP_CYCLES(REP)) dut (
      .clk       (clk),
      .reset     (reset),
      .btn_raw   (raw),
      .btn_pulse (btn_pulse),
      .btn_level (btn_level)
   );

   always #5 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   // Reference model: sync value is raw sampled two edges back; a level change is
   // accepted on the (DB+1)th consecutive edge where sync differs from the level.
   logic [N-1:0] h1, h2;
   logic [N-1:0] m_level, m_pulse;
   int           m_run  [N];
   int           m_held [N];

   int edge_idx;
   int first_pulse [N];
   int last_pulse  [N];
   int n_pulse     [N];
   int fall_edge   [N];
   logic [N-1:0] prev_level;

   task automatic model_reset();
      h1 = '0; h2 = '0; m_level = '0; m_pulse = '0;
      for (int i = 0; i < N; i++) begin
         m_run[i] = 0; m_held[i] = 0;
      end
   endtask

   task automatic model_edge();
      logic [N-1:0] s;
      s = h2;
      for (int i = 0; i < N; i++) begin
         logic stable_held;
         m_pulse[i] = 1'b0;
         stable_held = m_level[i] && (m_run[i] == 0) && s[i];
         if (REP_ON && stable_held) begin
            m_held[i]++;
            if (m_held[i] == REP) begin
               m_pulse[i] = 1'b1;
               m_held[i]  = 0;
            end
         end else begin
            m_held[i] = 0;
         end
         if (s[i] != m_level[i]) m_run[i]++;
         else                     m_run[i] = 0;
         if (m_run[i] == DB + 1) begin
            m_level[i] = ~m_level[i];
            m_pulse[i] = m_level[i];
            m_run[i]   = 0;
            m_held[i]  = 0;
         end
      end
      h2 = h1;
      h1 = raw;
   endtask

   task automatic check_vec(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s edge=%0d observed=%b expected=%b", tag, edge_idx, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clear_stats();
      edge_idx = 0;
      for (int i = 0; i < N; i++) begin
         first_pulse[i] = -1; last_pulse[i] = -1; n_pulse[i] = 0; fall_edge[i] = -1;
      end
   endtask

   // One clock: update model at the edge, compare 1 time unit later, return at edge+2.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         if (reset) model_edge();
         #1;
         check_vec("pulse", btn_pulse, m_pulse);
         check_vec("level", btn_level, m_level);
         for (int i = 0; i < N; i++) begin
            if (btn_pulse[i] === 1'b1) begin
               n_pulse[i]++;
               if (first_pulse[i] < 0) first_pulse[i] = edge_idx;
               last_pulse[i] = edge_idx;
            end
            if (prev_level[i] === 1'b1 && btn_level[i] === 1'b0 && fall_edge[i] < 0)
               fall_edge[i] = edge_idx;
         end
         prev_level = btn_level;
         edge_idx++;
         #1;
      end
   endtask

   initial begin
      prev_level = '0;
      model_reset();
      clear_stats();
      reset = 1'b1;
      raw   = '1;
      #1 reset = 1'b0;

      // Reset held with all buttons pressed: outputs stay low.
      step(5);
      check_vec("rst_pulse", btn_pulse, 3'b000);
      check_vec("rst_level", btn_level, 3'b000);
      raw   = '0;
      reset = 1'b1;
      step(8);

      // Clean press on channel 0, then release.
      raw = 3'b001; clear_stats(); step(20);
      check_int("press_edge", first_pulse[0], 6);
      check_int("press_count", n_pulse[0], REP_ON ? 2 : 1);
      raw = 3'b000; clear_stats(); step(12);
      check_int("release_edge", fall_edge[0], 6);
      check_int("release_pulses", n_pulse[0], 0);

      // Bouncing press on channel 1, then a short glitch.
      clear_stats();
      raw = 3'b010; step(2);
      raw = 3'b000; step(2);
      raw = 3'b010; step(2);
      raw = 3'b000; step(2);
      raw = 3'b010; step(12);
      check_int("bounce_count", n_pulse[1], 1);
      check_int("bounce_edge", first_pulse[1], 8 + 6);
      raw = 3'b000; step(12);
      clear_stats();
      raw = 3'b010; step(3);
      raw = 3'b000; step(10);
      check_int("glitch_count", n_pulse[1], 0);

      // Simultaneous presses on channels 0 and 2.
      raw = 3'b101; clear_stats(); step(10);
      check_int("simul_edge0", first_pulse[0], 6);
      check_int("simul_edge2", first_pulse[2], 6);
      check_int("simul_ch1", n_pulse[1], 0);
      raw = 3'b000; step(12);

      // Reset while channel 2 is held: outputs drop immediately, then a fresh press.
      raw = 3'b100; step(10);
      reset = 1'b0;
      model_reset();
      #1;
      check_vec("midrst_level", btn_level, 3'b000);
      check_vec("midrst_pulse", btn_pulse, 3'b000);
      step(2);
      reset = 1'b1; clear_stats(); step(10);
      check_int("after_rst_edge", first_pulse[2], 6);
      check_int("after_rst_count", n_pulse[2], 1);
      raw = 3'b000; step(12);

      // Long hold: repeat pulses every REP cycles when enabled.
      raw = 3'b001; clear_stats(); step(32);
      check_int("hold_count", n_pulse[0], REP_ON ? 4 : 1);
      check_int("hold_last", last_pulse[0], REP_ON ? 30 : 6);
      raw = 3'b000; step(12);

      // Random slowly-varying inputs with occasional glitches.
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 9) == 0) raw[i] = ~raw[i];
         step(1);
      end
      raw = '0; step(12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
